// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the MDU sequencing controller: MDU control codes,
// EX-stage request opcodes and controller state encoding.
package mdu_ctrl_pkg;

  localparam logic [4:0] MDU_NONE  = 5'd0;
  localparam logic [4:0] MDU_MULT  = 5'd1;
  localparam logic [4:0] MDU_MULTU = 5'd2;
  localparam logic [4:0] MDU_DIV   = 5'd3;
  localparam logic [4:0] MDU_DIVU  = 5'd4;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } req_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_ctrl.sv
// MDU sequencing controller: issues mult/div work, stalls IF..EX during divides,
// owns HI/LO. Optional macro MDU_DIVZERO_EN retires zero-divisor divides locally.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           stall_in,
  input  logic           req_valid,
  input  logic [2:0]     req_op,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  output logic [4:0]     mdu_control,
  output logic [W-1:0]   mdu_a,
  output logic [W-1:0]   mdu_b,
  output logic           mdu_en,
  output logic           mdu_clear,
  input  logic [2*W-1:0] mdu_result,
  input  logic           mdu_ready,
  output logic           stall_out,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo
);

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic           sgn_q, sgn_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic           accept_s;
  logic           divzero_s;

  assign accept_s = req_valid & ~flush & (state_q == ST_IDLE);

`ifdef MDU_DIVZERO_EN
  assign divzero_s = (req_b == {W{1'b0}});
`else
  assign divzero_s = 1'b0;
`endif

  // Next-state, HI/LO update and MDU drive for the current cycle.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sgn_d       = sgn_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mdu_control = MDU_NONE;
    mdu_a       = req_a;
    mdu_b       = req_b;
    mdu_en      = 1'b0;
    mdu_clear   = 1'b0;
    stall_out   = 1'b0;
    if (rst) begin
      mdu_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            case (req_op)
              OP_MULT, OP_MULTU: begin
                mdu_control = (req_op == OP_MULT) ? MDU_MULT : MDU_MULTU;
                if (!stall_in) begin
                  {hi_d, lo_d} = mdu_result;
                end else begin
                  {hi_d, lo_d} = {hi_q, lo_q};
                end
              end
              OP_MTHI: begin
                if (!stall_in) hi_d = req_a;
                else           hi_d = hi_q;
              end
              OP_MTLO: begin
                if (!stall_in) lo_d = req_a;
                else           lo_d = lo_q;
              end
              OP_DIV, OP_DIVU: begin
                // Zero divisor retires here like a multiply, never reaching the MDU.
                if (divzero_s) begin
                  if (!stall_in) begin
                    hi_d = req_a;
                    lo_d = {W{1'b1}};
                  end else begin
                    {hi_d, lo_d} = {hi_q, lo_q};
                  end
                end else begin
                  mdu_control = (req_op == OP_DIV) ? MDU_DIV : MDU_DIVU;
                  a_d         = req_a;
                  b_d         = req_b;
                  sgn_d       = (req_op == OP_DIV);
                  state_d     = ST_BUSY;
                  stall_out   = 1'b1;
                end
              end
              default: state_d = ST_IDLE;
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          mdu_a       = a_q;
          mdu_b       = b_q;
          mdu_control = sgn_q ? MDU_DIV : MDU_DIVU;
          if (flush) begin
            mdu_clear = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            mdu_en = 1'b1;
            if (mdu_ready) begin
              {hi_d, lo_d} = mdu_result;
              state_d      = stall_in ? ST_DONE : ST_IDLE;
            end else begin
              stall_out = 1'b1;
            end
          end
        end
        ST_DONE: begin
          // The held divide already committed; wait for EX to move on.
          if (flush || !stall_in) state_d = ST_IDLE;
          else                    state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, operand latches and HI/LO registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      sgn_q   <= 1'b0;
      hi_q    <= {W{1'b0}};
      lo_q    <= {W{1'b0}};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl with a behavioural MDU stand-in and a
// reference model of HI/LO effects per instruction.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int W       = 32;
  localparam int DIV_LAT = 5;

  logic           clk = 1'b0;
  logic           rst, flush, stall_in, req_valid;
  logic [2:0]     req_op;
  logic [W-1:0]   req_a, req_b;
  logic [4:0]     mdu_control;
  logic [W-1:0]   mdu_a, mdu_b, hi, lo;
  logic           mdu_en, mdu_clear, mdu_ready, stall_out;
  logic [2*W-1:0] mdu_result;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt      = 0;
  int div_starts = 0;
  int clears     = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] prev = 64'd0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  mdu_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .mdu_control(mdu_control), .mdu_a(mdu_a), .mdu_b(mdu_b),
    .mdu_en(mdu_en), .mdu_clear(mdu_clear), .mdu_result(mdu_result),
    .mdu_ready(mdu_ready), .stall_out(stall_out), .hi(hi), .lo(lo)
  );

  // Architectural effect of one instruction on {hi, lo}.
  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] oh,
                                         input logic [31:0] ol);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_DIV:   if (b == 32'd0) return {a, 32'hFFFFFFFF};
                else return {32'(sa % sb), 32'(sa / sb)};
      OP_DIVU:  if (b == 32'd0) return {a, 32'hFFFFFFFF};
                else return {a % b, a / b};
      OP_MTHI:  return {a, ol};
      OP_MTLO:  return {oh, a};
      default:  return {oh, ol};
    endcase
  endfunction

  function automatic logic [63:0] mdu_model(input logic [4:0] ctl, input logic [31:0] a,
                                            input logic [31:0] b);
    case (ctl)
      MDU_MULT:  return ref_op(OP_MULT,  a, b, 32'd0, 32'd0);
      MDU_MULTU: return ref_op(OP_MULTU, a, b, 32'd0, 32'd0);
      MDU_DIV:   return ref_op(OP_DIV,   a, b, 32'd0, 32'd0);
      MDU_DIVU:  return ref_op(OP_DIVU,  a, b, 32'd0, 32'd0);
      default:   return 64'hBADC0FFEE0DDF00D;
    endcase
  endfunction

  assign mdu_result = mdu_model(mdu_control, mdu_a, mdu_b);
  assign mdu_ready  = mdu_en && (cnt == DIV_LAT - 1);

  always @(posedge clk) begin
    if (mdu_en && cnt == 0 && !mdu_clear) div_starts++;
    if (mdu_clear) clears++;
    if (mdu_clear || mdu_ready) cnt <= 0;
    else if (mdu_en)            cnt <= cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic expect_hilo(input logic [31:0] h, input logic [31:0] l);
    if ({h, l} != {m_hi, m_lo}) exp_q.push_back({h, l});
    m_hi = h;
    m_lo = l;
  endtask

  // Monitor: every visible HI/LO change must match the next scoreboard entry.
  always @(negedge clk) begin
    if (mon_en && {hi, lo} !== prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL hilo_unexpected: got %h expected %h", {hi, lo}, prev);
      end else begin
        check("hilo_write", {hi, lo}, exp_q.pop_front());
      end
      prev = {hi, lo};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_simple(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int stalls);
    logic [63:0] r;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    stall_in  = (stalls > 0);
    for (int i = 0; i < stalls; i++) begin
      @(negedge clk);
      check("simple_stall_out_held", {63'd0, stall_out}, 64'd0);
      tick();
    end
    stall_in = 1'b0;
    r = ref_op(op, a, b, m_hi, m_lo);
    expect_hilo(r[63:32], r[31:0]);
    @(negedge clk);
    check("simple_stall_out", {63'd0, stall_out}, 64'd0);
    tick();
    req_valid = 1'b0;
  endtask

  // flush_at: -1 none, 0 in the ready cycle, n in the n-th busy cycle.
  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input int done_hold, input bit done_flush);
    int cyc;
    bit done;
    bit flushed;
    int starts0;
    int clears0;
    logic [63:0] r;
    starts0 = div_starts;
    clears0 = clears;
    flushed = 1'b0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    stall_in  = (done_hold > 0);
    @(negedge clk);
    check("div_accept_stall", {63'd0, stall_out}, 64'd1);
    tick();
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc < 64) begin
      if (flush_at == cyc || (flush_at == 0 && mdu_ready)) begin
        flush = 1'b1;
        @(negedge clk);
        check("flush_clear", {63'd0, mdu_clear}, 64'd1);
        check("flush_stall", {63'd0, stall_out}, 64'd0);
        tick();
        flush = 1'b0; req_valid = 1'b0; stall_in = 1'b0;
        flushed = 1'b1;
        done = 1'b1;
      end else begin
        @(negedge clk);
        if (mdu_ready) begin
          check("div_ready_stall", {63'd0, stall_out}, 64'd0);
          r = ref_op(op, a, b, m_hi, m_lo);
          expect_hilo(r[63:32], r[31:0]);
          tick();
          if (done_hold == 0) req_valid = 1'b0;
          done = 1'b1;
        end else begin
          check("div_busy_stall", {63'd0, stall_out}, 64'd1);
          tick();
          cyc++;
        end
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL div_timeout: got no ready expected ready within 64 cycles");
      req_valid = 1'b0; stall_in = 1'b0;
    end
    if (done && !flushed && done_hold > 0) begin
      if (done_flush) begin
        flush = 1'b1;
        @(negedge clk);
        check("done_flush_stall", {63'd0, stall_out}, 64'd0);
        tick();
        flush = 1'b0; stall_in = 1'b0; req_valid = 1'b0;
      end else begin
        for (int i = 0; i < done_hold; i++) begin
          @(negedge clk);
          check("done_stall", {63'd0, stall_out}, 64'd0);
          tick();
        end
        stall_in = 1'b0;
        @(negedge clk);
        check("done_release_stall", {63'd0, stall_out}, 64'd0);
        tick();
        req_valid = 1'b0;
      end
    end
    check("div_issue_once", 64'(div_starts - starts0), 64'd1);
    if (flushed) check("clear_pulse_once", 64'(clears - clears0), 64'd1);
  endtask

  initial begin
    logic [2:0] op;
    rst = 1'b1; flush = 1'b0; stall_in = 1'b0; req_valid = 1'b0;
    req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
    tick();
    @(negedge clk);
    check("rst_clear", {63'd0, mdu_clear}, 64'd1);
    check("rst_stall", {63'd0, stall_out}, 64'd0);
    check("rst_en", {63'd0, mdu_en}, 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_ctl", {59'd0, mdu_control}, {59'd0, MDU_NONE});
    check("rst_clear_off", {63'd0, mdu_clear}, 64'd0);
    prev   = {hi, lo};
    mon_en = 1'b1;
    tick();

    run_simple(OP_MULT, 32'hFFFFFFFD, 32'd5, 0);
    @(negedge clk);
    check("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    tick();

    run_div(OP_DIVU, 32'd100, 32'd7, -1, 0, 1'b0);
    @(negedge clk);
    check("divu_const", {hi, lo}, {32'd2, 32'd14});
    tick();

    run_div(OP_DIV, 32'hFFFFFFF9, 32'd2, -1, 2, 1'b0);
    @(negedge clk);
    check("div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    tick();

    run_div(OP_DIVU, 32'd100, 32'd7, 3, 0, 1'b0);
    run_simple(OP_MTHI, 32'h1234, 32'd0, 0);
    @(negedge clk);
    check("mthi_after_flush", {32'd0, hi}, 64'h1234);
    tick();

    run_div(OP_DIV, 32'd1000, 32'd3, 0, 0, 1'b0);
    run_div(OP_DIVU, 32'd55, 32'd4, -1, 2, 1'b1);
    run_simple(OP_MULT, 32'd11, 32'd13, 0);

    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd7; req_b = 32'd9; flush = 1'b1;
    @(negedge clk);
    check("idle_flush_stall", {63'd0, stall_out}, 64'd0);
    tick();
    req_valid = 1'b0; flush = 1'b0;

    run_simple(OP_MULTU, $urandom, $urandom, 2);
    run_simple(OP_MTLO, $urandom, $urandom, 1);

`ifdef MDU_DIVZERO_EN
    run_simple(OP_DIV, 32'h55, 32'd0, 0);
`else
    run_div(OP_DIV, 32'h55, 32'd0, -1, 0, 1'b0);
`endif
    @(negedge clk);
    check("div_by_zero", {hi, lo}, {32'h55, 32'hFFFFFFFF});
    tick();

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      if (op == OP_DIV || op == OP_DIVU)
        run_div(op, $urandom, $urandom_range(1, 1000), -1, int'($urandom_range(0, 1)), 1'b0);
      else
        run_simple(op, $urandom, $urandom, int'($urandom_range(0, 2)));
    end

    req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd100; req_b = 32'd7;
    tick();
    tick();
    rst = 1'b1;
    expect_hilo(32'd0, 32'd0);
    @(negedge clk);
    check("busy_rst_clear", {63'd0, mdu_clear}, 64'd1);
    check("busy_rst_stall", {63'd0, stall_out}, 64'd0);
    tick();
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("post_rst_hilo", {hi, lo}, 64'd0);
    check("post_rst_stall", {63'd0, stall_out}, 64'd0);
    check("post_rst_en", {63'd0, mdu_en}, 64'd0);
    tick();

    repeat (3) tick();
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
